// File: rtl/uart_tx_queue.sv
// Byte FIFO that paces issues to a busy-less UART transmitter, one byte per SPACING cycles.
// Issue 1 cycle after first write; writes while full are dropped. Optional sticky ovf via UART_TXQ_OVF_EN.
module uart_tx_queue #(
   parameter int BAUD       = 115200,
   parameter int CLK_FREQ   = 27_000_000,
   parameter int DEPTH_LOG2 = 4
) (
   input  logic                  sys_clk,
   input  logic                  sys_rst_n,
   input  logic [7:0]            wr_data,
   input  logic                  wr_en,
   output logic                  full,
   output logic                  empty,
   output logic [DEPTH_LOG2:0]   level,
   output logic                  busy,
   output logic [7:0]            po_data,
   output logic                  po_flag,
   output logic                  ovf
);

   localparam int BIT_CYC = CLK_FREQ / BAUD;
   localparam int SPACING = 10 * BIT_CYC + 2;
   localparam int GAP_W   = $clog2(SPACING);
   localparam int DEPTH   = 1 << DEPTH_LOG2;

   typedef enum logic {IDLE, HOLD} state_t;

   state_t                state_q, state_d;
   logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [DEPTH_LOG2:0]   level_q, level_d;
   logic [GAP_W-1:0]      gap_q, gap_d;
   logic [7:0]            po_data_q, po_data_d;
   logic                  po_flag_q, po_flag_d;
   logic                  full_q, empty_q;
   logic [7:0]            mem [DEPTH];
   logic                  push, pop;

   assign push = wr_en && !full_q;
   assign pop  = (state_q == IDLE) && (level_q != '0);

   always_comb begin
      state_d   = state_q;
      gap_d     = gap_q;
      po_data_d = po_data_q;
      po_flag_d = 1'b0;
      rd_ptr_d  = rd_ptr_q;
      wr_ptr_d  = wr_ptr_q;
      level_d   = level_q;

      case (state_q)
         IDLE: begin
            if (pop) begin
               state_d   = HOLD;
               po_data_d = mem[rd_ptr_q];
               po_flag_d = 1'b1;
               rd_ptr_d  = rd_ptr_q + 1'b1;
            end
         end
         HOLD: begin
            // Leaving on count SPACING-2 puts the next issue edge exactly SPACING cycles after this one.
            if (gap_q == GAP_W'(SPACING - 2)) begin
               state_d = IDLE;
               gap_d   = '0;
            end else begin
               gap_d = gap_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      if (push) wr_ptr_d = wr_ptr_q + 1'b1;

      case ({push, pop})
         2'b10:   level_d = level_q + 1'b1;
         2'b01:   level_d = level_q - 1'b1;
         default: level_d = level_q;
      endcase
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q   <= IDLE;
         rd_ptr_q  <= '0;
         wr_ptr_q  <= '0;
         level_q   <= '0;
         gap_q     <= '0;
         po_data_q <= 8'h00;
         po_flag_q <= 1'b0;
         full_q    <= 1'b0;
         empty_q   <= 1'b1;
      end else begin
         state_q   <= state_d;
         rd_ptr_q  <= rd_ptr_d;
         wr_ptr_q  <= wr_ptr_d;
         level_q   <= level_d;
         gap_q     <= gap_d;
         po_data_q <= po_data_d;
         po_flag_q <= po_flag_d;
         full_q    <= (level_d == (DEPTH_LOG2+1)'(DEPTH));
         empty_q   <= (level_d == '0);
      end
   end

   // Storage needs no reset; only entries below the level are ever read.
   always_ff @(posedge sys_clk) begin
      if (push) mem[wr_ptr_q] <= wr_data;
   end

`ifdef UART_TXQ_OVF_EN
   logic ovf_q;
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n)          ovf_q <= 1'b0;
      else if (wr_en && full_q) ovf_q <= 1'b1;
   end
   assign ovf = ovf_q;
`else
   assign ovf = 1'b0;
`endif

   assign full    = full_q;
   assign empty   = empty_q;
   assign level   = level_q;
   assign busy    = (state_q == HOLD);
   assign po_data = po_data_q;
   assign po_flag = po_flag_q;

endmodule

// File: tb/tb_uart_tx_queue.sv
// Scoreboard bench for uart_tx_queue: stimulus pushes expected bytes, a negedge monitor checks every issue.
module tb_uart_tx_queue;

   localparam int CLK_FREQ = 1000;
   localparam int BAUD     = 100;
   localparam int DL       = 4;
   localparam int SPACING  = 102;   // 10*(1000/100)+2
`ifdef UART_TXQ_OVF_EN
   localparam logic OVF_EXP = 1'b1;
`else
   localparam logic OVF_EXP = 1'b0;
`endif

   logic        sys_clk = 1'b0;
   logic        sys_rst_n = 1'b0;
   logic [7:0]  wr_data = 8'h00;
   logic        wr_en = 1'b0;
   logic        full, empty, busy, po_flag, ovf;
   logic [DL:0] level;
   logic [7:0]  po_data;

   uart_tx_queue #(.BAUD(BAUD), .CLK_FREQ(CLK_FREQ), .DEPTH_LOG2(DL)) dut (
      .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .wr_data(wr_data), .wr_en(wr_en),
      .full(full), .empty(empty), .level(level), .busy(busy),
      .po_data(po_data), .po_flag(po_flag), .ovf(ovf)
   );

   always #5 sys_clk = ~sys_clk;

   int          n_cmp = 0;
   int          n_bad = 0;
   byte unsigned exp_q[$];
   int          cyc = 0;
   int          last_cyc = 0;
   int          flag_cnt = 0;
   logic        have_last = 1'b0;
   logic        prev_flag = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(posedge sys_clk) cyc <= cyc + 1;

   // Monitor: every issue pulse is matched against the scoreboard and timed.
   always @(negedge sys_clk) begin
      if (!sys_rst_n) begin
         have_last = 1'b0;
         prev_flag = 1'b0;
      end else begin
         if (po_flag) begin
            flag_cnt++;
            check("pulse_width", {31'd0, prev_flag}, 0);
            if (exp_q.size() == 0) check("issue_with_empty_queue", {31'd0, po_flag}, 0);
            else check("issue_data", {24'd0, po_data}, {24'd0, exp_q.pop_front()});
            if (have_last) check("issue_spacing", cyc - last_cyc, SPACING);
            have_last = 1'b1;
            last_cyc  = cyc;
         end
         prev_flag = po_flag;
      end
   end

   task automatic drive_burst(input int first, input int n, input int n_accept);
      for (int i = 0; i < n; i++) begin
         wr_en   = 1'b1;
         wr_data = 8'(first + i);
         if (i < n_accept) exp_q.push_back(8'(first + i));
         @(negedge sys_clk);
      end
      wr_en = 1'b0;
   endtask

   task automatic wait_drain(input string name);
      int k;
      k = 0;
      while ((exp_q.size() != 0 || busy) && k < 45 * SPACING) begin
         @(negedge sys_clk);
         k++;
      end
      check({name, "_drained"}, exp_q.size(), 0);
      check({name, "_idle"}, {31'd0, busy}, 0);
      have_last = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
      $fatal(1, "timeout");
   end

   initial begin
      int k, bcnt, fc;
      logic [DL:0] lv;

      repeat (3) @(negedge sys_clk);
      sys_rst_n = 1'b1;
      @(negedge sys_clk);
      check("rst_empty", {31'd0, empty}, 1);
      check("rst_full", {31'd0, full}, 0);
      check("rst_level", {27'd0, level}, 0);
      check("rst_po_flag", {31'd0, po_flag}, 0);
      check("rst_po_data", {24'd0, po_data}, 8'h00);
      check("rst_busy", {31'd0, busy}, 0);
      check("rst_ovf", {31'd0, ovf}, 0);

      // Single byte: level after edge N, issue after edge N+1, busy for SPACING-1 cycles.
      wr_en = 1'b1; wr_data = 8'hA5; exp_q.push_back(8'hA5);
      @(negedge sys_clk);
      wr_en = 1'b0;
      check("single_level_n", {27'd0, level}, 1);
      check("single_flag_n", {31'd0, po_flag}, 0);
      @(negedge sys_clk);
      check("single_flag_n1", {31'd0, po_flag}, 1);
      check("single_data_n1", {24'd0, po_data}, 8'hA5);
      check("single_level_n1", {27'd0, level}, 0);
      bcnt = 0; k = 0;
      while (busy && k < 2 * SPACING) begin
         bcnt++;
         @(negedge sys_clk);
         k++;
      end
      check("single_busy_cycles", bcnt, SPACING - 1);
      check("single_data_held", {24'd0, po_data}, 8'hA5);
      wait_drain("single");

      // Burst of five: the first is popped while the rest are still arriving.
      drive_burst(8'h01, 5, 5);
      check("burst_level", {27'd0, level}, 4);
      wait_drain("burst");

      // Fill during HOLD: 16 accepted, 17th dropped.
      wr_en = 1'b1; wr_data = 8'h30; exp_q.push_back(8'h30);
      @(negedge sys_clk);
      wr_en = 1'b0;
      @(negedge sys_clk);
      check("fill_busy", {31'd0, busy}, 1);
      drive_burst(8'h40, 17, 16);
      check("fill_full", {31'd0, full}, 1);
      check("fill_level", {27'd0, level}, 16);
      check("fill_empty", {31'd0, empty}, 0);
      check("fill_ovf", {31'd0, ovf}, {31'd0, OVF_EXP});
      wait_drain("fill");
      check("fill_ovf_sticky", {31'd0, ovf}, {31'd0, OVF_EXP});
      check("fill_empty_after", {31'd0, empty}, 1);
      check("fill_full_after", {31'd0, full}, 0);

      // Wrap: 40 bytes, writes 3..39 land exactly on issue edges.
      drive_burst(8'h80, 3, 3);
      check("wrap_prefill_level", {27'd0, level}, 2);
      for (int i = 3; i < 40; i++) begin
         k = 0;
         while (busy && k < 2 * SPACING) begin
            @(negedge sys_clk);
            k++;
         end
         lv = level;
         wr_en = 1'b1; wr_data = 8'(8'h80 + i); exp_q.push_back(8'(8'h80 + i));
         @(negedge sys_clk);
         wr_en = 1'b0;
         check("simul_level", {27'd0, level}, {27'd0, lv});
         check("simul_issue", {31'd0, po_flag}, 1);
      end
      wait_drain("wrap");

      // Reset during HOLD with three bytes queued.
      drive_burst(8'hC0, 4, 4);
      check("rst_mid_level", {27'd0, level}, 3);
      check("rst_mid_busy", {31'd0, busy}, 1);
      #2 sys_rst_n = 1'b0;
      #1;
      check("rst_mid_po_flag", {31'd0, po_flag}, 0);
      check("rst_mid_po_data", {24'd0, po_data}, 8'h00);
      check("rst_mid_level0", {27'd0, level}, 0);
      check("rst_mid_busy0", {31'd0, busy}, 0);
      check("rst_mid_empty", {31'd0, empty}, 1);
      check("rst_mid_full", {31'd0, full}, 0);
      check("rst_mid_ovf", {31'd0, ovf}, 0);
      exp_q.delete();
      fc = flag_cnt;
      repeat (2) @(negedge sys_clk);
      sys_rst_n = 1'b1;
      repeat (3 * SPACING) @(negedge sys_clk);
      check("no_issue_after_reset", flag_cnt - fc, 0);
      wr_en = 1'b1; wr_data = 8'hD5; exp_q.push_back(8'hD5);
      @(negedge sys_clk);
      wr_en = 1'b0;
      wait_drain("post_reset");
      check("post_reset_issues", flag_cnt - fc, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
